uart_rx_frontend: RTL and testbench

Receive-side serial front end of the AXI4-Lite UART. It sits between the external `rxd` pin and the RX FIFO inside `uart_wrapper`. It synchronises `rxd`, oversamples it at 16x the baud rate and frames 8N1 characters. It presents each received byte to the FIFO over a valid/ready handshake and flags framing, overrun and break conditions to the control/interrupt logic.

---
 rtl/uart_rx_frontend.sv | 109 ++++++++++
 tb/tb_uart_rx_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: synchronise rxd, oversample at 16x and frame 8N1 bytes onto a valid/ready output
module uart_rx_frontend #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_WIDTH-1:0] baud_div,
   input  logic                 rx_enable,
   input  logic                 rxd,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 break_det,
   output logic                 rx_busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   localparam logic [DIV_WIDTH-1:0] one = 1;
   state_t state, state_n;
   logic [1:0] sync;
   logic rxd_s, tick, decide, maj, start_det, deliver, ferr, brk, s7, s8;
   logic [DIV_WIDTH-1:0] dcnt, div_m1;
   logic [3:0] scnt;
   logic [2:0] bcnt;
   logic [7:0] sh;
   assign rxd_s = sync[1];
   assign div_m1 = (baud_div == '0) ? '0 : baud_div - one;
   assign tick = dcnt >= div_m1;
   assign decide = tick && scnt == 4'd9;
   assign maj = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
   assign start_det = state == IDLE && rx_enable && !rxd_s;
   assign rx_busy = state != IDLE;
   // two-flop synchroniser, idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else sync <= {sync[0], rxd};
   end
   // divisor/sample counters, phase-aligned to the start edge; majority samples and data shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt <= '0;
         scnt <= '0;
         s7 <= 1'b1;
         s8 <= 1'b1;
         bcnt <= '0;
         sh <= '0;
      end else if (start_det) begin
         dcnt <= '0;
         scnt <= '0;
         bcnt <= '0;
      end else if (tick) begin
         dcnt <= '0;
         scnt <= scnt + 4'd1;
         if (scnt == 4'd7) s7 <= rxd_s;
         if (scnt == 4'd8) s8 <= rxd_s;
         if (decide && state == DATA) begin
            sh <= {maj, sh[7:1]};
            bcnt <= bcnt + 3'd1;
         end
      end else dcnt <= dcnt + one;
   end
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   // next state and stop-bit outcome
   always_comb begin
      state_n = state;
      deliver = 1'b0;
      ferr = 1'b0;
      brk = 1'b0;
      if (!rx_enable) state_n = IDLE;
      else
         case (state)
            IDLE:      if (!rxd_s) state_n = START;
            START:     if (decide) state_n = maj ? IDLE : DATA;
            DATA:      if (decide && bcnt == 3'd7) state_n = STOP;
            STOP:
               if (decide) begin
                  state_n = maj ? IDLE : WAIT_HIGH;
                  deliver = maj;
                  brk = !maj && sh == 8'h00;
                  ferr = !maj && sh != 8'h00;
               end
            WAIT_HIGH: if (rxd_s) state_n = IDLE;
            default:   state_n = IDLE;
         endcase
   end
   // output holding register, handshake and one-cycle error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun_err <= 1'b0;
         break_det <= 1'b0;
      end else begin
         frame_err <= ferr;
         break_det <= brk;
         overrun_err <= deliver && rx_valid && !rx_ready;
         if (deliver && (!rx_valid || rx_ready)) begin
            rx_data <= sh;
            rx_valid <= 1'b1;
         end else if (rx_ready) rx_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed and randomized 8N1 frames checked against an event-level reference model
module tb_uart_rx_frontend;
   typedef struct {int kind; logic [7:0] data; longint due; longint tol;} ev_t;
   logic clk = 0, rst = 1, rx_enable = 1, rxd = 1, rx_ready = 0;
   logic [15:0] baud_div = 16'd54;
   logic [7:0] rx_data;
   logic rx_valid, frame_err, overrun_err, break_det, rx_busy;
   int checks = 0, errors = 0, rdy_thr = 8;
   int n_fe = 0, n_brk = 0, n_ovr = 0;
   longint cyc = 0, last_c0 = 0, last_ld_cyc = -1;
   logic [7:0] last_ld_data = 0, m_data = 0;
   bit m_valid = 0, rdy_used = 0;
   ev_t q[$];

   uart_rx_frontend #(.DIV_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .baud_div(baud_div), .rx_enable(rx_enable), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
      .overrun_err(overrun_err), .break_det(break_det), .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int eff_div();
      return (baud_div == 0) ? 1 : int'(baud_div);
   endfunction

   // 8N1 frame from the line's point of view; the outcome is known once the frame is chosen
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit exp);
      int bt;
      ev_t e;
      bt = 16 * eff_div();
      @(negedge clk);
      rxd = 0;
      last_c0 = cyc;
      if (exp) begin
         e.kind = stop_ok ? 0 : (d == 8'h00 ? 2 : 1);
         e.data = d;
         e.due = cyc + 3 + 154 * eff_div();
         e.tol = 2 * eff_div() + 4;
         q.push_back(e);
      end
      for (int i = 0; i < 8; i++) begin
         repeat (bt) @(negedge clk);
         rxd = d[i];
      end
      repeat (bt) @(negedge clk);
      rxd = stop_ok;
      repeat (bt) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rxd = 1;
      repeat (n * 16 * eff_div()) @(negedge clk);
   endtask

   task automatic set_ready(input int thr);
      @(negedge clk);
      #2 rdy_thr = thr;
   endtask

   initial forever begin
      @(negedge clk);
      rx_ready = ($urandom_range(0, 7) < rdy_thr);
   end

   // reference compare: ordered expected outcomes plus a model of the output holding register
   initial begin
      ev_t e;
      bit xfer, ld;
      logic [3:0] act, expm;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            m_valid = 0;
            q.delete();
            rdy_used = rx_ready;
         end else begin
            expm = 4'b0000;
            xfer = m_valid && rdy_used;
            ld = rx_valid && (!m_valid || xfer);
            act = {ld, overrun_err, break_det, frame_err};
            n_fe += frame_err;
            n_brk += break_det;
            n_ovr += overrun_err;
            if (q.size() > 0 && cyc > q[0].due + q[0].tol) begin
               checks++;
               errors++;
               $display("FAIL event_missing: got none expected kind %0d data %0h by cycle %0d", q[0].kind, q[0].data, q[0].due + q[0].tol);
               void'(q.pop_front());
            end
            if (act != 4'b0000) begin
               if (q.size() == 0) chk("spurious_event", act, 4'b0000);
               else begin
                  e = q.pop_front();
                  expm = e.kind == 1 ? 4'b0001 : e.kind == 2 ? 4'b0010 : (!m_valid || xfer) ? 4'b1000 : 4'b0100;
                  chk("event_kind", act, expm);
                  chk("event_time", (cyc >= e.due - e.tol && cyc <= e.due + e.tol), 1);
                  if (expm == 4'b1000) m_data = e.data;
               end
               if (ld) begin
                  last_ld_cyc = cyc;
                  last_ld_data = rx_data;
               end
            end
            m_valid = (expm == 4'b1000) ? 1'b1 : xfer ? 1'b0 : m_valid;
            chk("rx_valid", rx_valid, m_valid);
            if (m_valid) chk("rx_data", rx_data, m_data);
            rdy_used = rx_ready;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int fe0, brk0, ovr0, div;
      logic [7:0] d;
      bit ok;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {rx_data, rx_valid, frame_err, overrun_err, break_det, rx_busy}, 0);
      #1 rst = 0;
      // clean byte at the nominal divisor
      idle_bits(1);
      send_frame(8'hA5, 1, 1);
      idle_bits(1);
      chk("a5_data", last_ld_data, 8'hA5);
      chk("a5_latency", (last_ld_cyc - last_c0 >= 8100 && last_ld_cyc - last_c0 <= 8400), 1);
      // glitch rejection, then a real byte
      baud_div = 8;
      idle_bits(1);
      @(negedge clk);
      rxd = 0;
      repeat (48) @(negedge clk);
      idle_bits(2);
      chk("glitch_busy", rx_busy, 0);
      send_frame(8'h3C, 1, 1);
      idle_bits(1);
      chk("3c_data", last_ld_data, 8'h3C);
      // framing error then recovery
      fe0 = n_fe;
      send_frame(8'h5A, 0, 1);
      idle_bits(2);
      chk("frame_err_count", n_fe - fe0, 1);
      send_frame(8'h81, 1, 1);
      idle_bits(1);
      chk("81_data", last_ld_data, 8'h81);
      // break: 20 bit times low
      brk0 = n_brk;
      fe0 = n_fe;
      send_frame(8'h00, 0, 1);
      repeat (10 * 16 * 8) @(negedge clk);
      idle_bits(2);
      chk("break_count", n_brk - brk0, 1);
      chk("break_no_fe", n_fe - fe0, 0);
      send_frame(8'h55, 1, 1);
      idle_bits(1);
      chk("55_data", last_ld_data, 8'h55);
      // backpressure and overrun
      set_ready(0);
      ovr0 = n_ovr;
      send_frame(8'h11, 1, 1);
      idle_bits(1);
      send_frame(8'h22, 1, 1);
      idle_bits(1);
      chk("ovr_count", n_ovr - ovr0, 1);
      chk("ovr_held_data", rx_data, 8'h11);
      chk("ovr_held_valid", rx_valid, 1);
      set_ready(8);
      set_ready(0);
      repeat (4) @(negedge clk);
      chk("ovr_drained", rx_valid, 0);
      // abort by rx_enable during bit 3
      set_ready(8);
      fork
         send_frame(8'hF0, 1, 0);
         begin
            repeat (4 * 128 + 64 + 1) @(negedge clk);
            chk("abort_busy_before", rx_busy, 1);
            #2 rx_enable = 0;
            @(negedge clk);
            #1 chk("abort_busy_after", rx_busy, 0);
         end
      join
      idle_bits(1);
      rx_enable = 1;
      idle_bits(1);
      // reset mid-frame with a byte held
      set_ready(0);
      send_frame(8'h77, 1, 1);
      idle_bits(1);
      fork
         send_frame(8'h99, 1, 0);
         begin
            repeat (5 * 128) @(negedge clk);
            chk("pre_rst_valid", rx_valid, 1);
            #2 rst = 1;
            #1 chk("rst_outputs", {rx_data, rx_valid, frame_err, overrun_err, break_det, rx_busy}, 0);
         end
      join
      idle_bits(1);
      @(negedge clk);
      #2 rst = 0;
      set_ready(8);
      idle_bits(1);
      send_frame(8'h7E, 1, 1);
      idle_bits(1);
      chk("7e_data", last_ld_data, 8'h7E);
      // randomized frames, divisors (including 0), gaps and backpressure
      for (int n = 0; n < 25; n++) begin
         div = $urandom_range(0, 6);
         @(negedge clk);
         baud_div = div[15:0];
         rdy_thr = $urandom_range(0, 8);
         d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
         ok = $urandom_range(0, 4) != 0;
         send_frame(d, ok, 1);
         idle_bits(ok ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      set_ready(8);
      idle_bits(4);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
